cpu_control_fsm: RTL and testbench

Multi-cycle control unit for the 32-bit CPU datapath. Each cycle it reads the decoded instruction fields and the ALU zero / register-hazard flags, and drives every datapath control strobe. Strobes cover PC load and PC source, register and memory writes, ALU operation, I/R/J type selects and write-back source. It also stalls on register hazards, halts on HALT or illegal opcodes, and keeps retire and stall counters.

---
 rtl/cpu_ctrl_pkg.sv | 31 +++
 rtl/ctrl_decoder.sv | 36 +++
 rtl/cpu_control_fsm.sv | 123 ++++++++++++
 tb/tb_cpu_control_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode, ALU-op and PC-select constants plus the control FSM state encoding
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] ALU_ADD = 6'h20;
    localparam logic [5:0] ALU_SUB = 6'h22;

    localparam logic [1:0] PC_PLUS1 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ADDR  = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_STALL,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_t;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational instruction classifier feeding the control FSM
module ctrl_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       is_r,
    output logic       is_i,
    output logic       is_j,
    output logic [5:0] opcode_alu,
    output logic       reads_rt,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       illegal
);

    logic is_addi;
    logic is_halt;

    // Classify the opcode; HALT is legal but belongs to no class
    always_comb begin
        is_r       = opcode == OP_R;
        is_addi    = opcode == OP_ADDI;
        is_load    = opcode == OP_LW;
        is_store   = opcode == OP_SW;
        is_branch  = opcode == OP_BEQ;
        is_j       = opcode == OP_J;
        is_halt    = opcode == OP_HALT;
        is_i       = is_addi || is_load || is_store || is_branch;
        opcode_alu = is_r ? funct : is_branch ? ALU_SUB : is_i ? ALU_ADD : 6'h00;
        reads_rt   = is_r || is_store || is_branch;
        illegal    = !(is_r || is_i || is_j || is_halt);
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control unit driving all datapath strobes, with hazard stalls and counters
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 is_alu_zero,
    input  logic                 is_full_rnum1,
    input  logic                 is_full_rnum2,
    output logic                 is_load_PC,
    output logic [1:0]           control_mux_for_PC,
    output logic                 is_write_reg,
    output logic                 is_write_mem,
    output logic                 is_write_from_mem,
    output logic                 is_R_type,
    output logic                 is_I_type,
    output logic                 is_J_type,
    output logic [5:0]           opcode_alu,
    output logic                 is_nop,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    state_t     state;
    state_t     ns;
    logic [5:0] ir_op;
    logic [5:0] ir_funct;
    logic       d_is_r;
    logic       d_is_i;
    logic       d_is_j;
    logic [5:0] d_opcode_alu;
    logic       d_reads_rt;
    logic       d_is_load;
    logic       d_is_store;
    logic       d_is_branch;
    logic       d_illegal;
    logic       hazard;
    logic       body;
    logic       sw_done;

    ctrl_decoder u_dec (
        .opcode     (ir_op),
        .funct      (ir_funct),
        .is_r       (d_is_r),
        .is_i       (d_is_i),
        .is_j       (d_is_j),
        .opcode_alu (d_opcode_alu),
        .reads_rt   (d_reads_rt),
        .is_load    (d_is_load),
        .is_store   (d_is_store),
        .is_branch  (d_is_branch),
        .illegal    (d_illegal)
    );

    // Next-state selection; outputs are decoded from the next state so they are registered
    always_comb begin
        hazard  = is_full_rnum1 || (d_reads_rt && is_full_rnum2);
        ns      = ST_FETCH;
        case (state)
            ST_FETCH:  ns = ST_DECODE;
            ST_DECODE: ns = (ir_op == OP_HALT || d_illegal) ? ST_HALT :
                            d_is_j ? ST_JUMP : hazard ? ST_STALL : ST_EXEC;
            ST_STALL:  ns = hazard ? ST_STALL : ST_EXEC;
            ST_EXEC:   ns = (d_is_load || d_is_store) ? ST_MEM :
                            d_is_branch ? ST_BRANCH : ST_WB;
            ST_MEM:    ns = d_is_load ? ST_WB : ST_FETCH;
            ST_HALT:   ns = ST_HALT;
            default:   ns = ST_FETCH;
        endcase
        body    = ns inside {ST_STALL, ST_EXEC, ST_MEM, ST_WB, ST_BRANCH};
        sw_done = ns == ST_MEM && d_is_store;
    end

    // State, instruction register, registered strobes and counters; the PC select taken on
    // entry to BRANCH doubles as the zero-flag register sampled at the end of EXEC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_FETCH;
            ir_op              <= '0;
            ir_funct           <= '0;
            is_load_PC         <= 1'b0;
            control_mux_for_PC <= PC_PLUS1;
            is_write_reg       <= 1'b0;
            is_write_mem       <= 1'b0;
            is_write_from_mem  <= 1'b0;
            is_R_type          <= 1'b0;
            is_I_type          <= 1'b0;
            is_J_type          <= 1'b0;
            opcode_alu         <= '0;
            is_nop             <= 1'b0;
            halted             <= 1'b0;
            retired            <= '0;
            stall_cycles       <= '0;
        end else begin
            state <= ns;
            if (state == ST_FETCH) begin
                ir_op    <= opcode;
                ir_funct <= funct;
            end
            is_load_PC         <= ns == ST_WB || ns == ST_BRANCH || ns == ST_JUMP || sw_done;
            control_mux_for_PC <= ns == ST_JUMP ? PC_ADDR :
                                  (ns == ST_BRANCH && is_alu_zero) ? PC_IMM : PC_PLUS1;
            is_write_reg       <= ns == ST_WB;
            is_write_mem       <= sw_done;
            is_write_from_mem  <= ns == ST_WB && d_is_load;
            is_R_type          <= body && d_is_r;
            is_I_type          <= body && d_is_i;
            is_J_type          <= ns == ST_JUMP;
            opcode_alu         <= body ? d_opcode_alu : 6'h00;
            is_nop             <= ns == ST_STALL;
            halted             <= ns == ST_HALT;
            retired            <= retired + CNT_WIDTH'(is_load_PC);
            if (is_nop && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed self-checking bench for the multi-cycle control FSM
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        is_alu_zero = 1'b0;
    logic        is_full_rnum1 = 1'b0;
    logic        is_full_rnum2 = 1'b0;
    logic        is_load_PC;
    logic [1:0]  control_mux_for_PC;
    logic        is_write_reg;
    logic        is_write_mem;
    logic        is_write_from_mem;
    logic        is_R_type;
    logic        is_I_type;
    logic        is_J_type;
    logic [5:0]  opcode_alu;
    logic        is_nop;
    logic        halted;
    logic [15:0] retired;
    logic [15:0] stall_cycles;
    logic [16:0] outs;

    int n_chk = 0;
    int n_pass = 0;
    int exp_ret = 0;
    int len, n_nop, n_wreg, n_wmem, n_load;
    logic [1:0] sel_q;
    logic [5:0] alu_q;
    logic r_q, i_q, j_q, fm_q;

    cpu_control_fsm #(.CNT_WIDTH(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .funct              (funct),
        .is_alu_zero        (is_alu_zero),
        .is_full_rnum1      (is_full_rnum1),
        .is_full_rnum2      (is_full_rnum2),
        .is_load_PC         (is_load_PC),
        .control_mux_for_PC (control_mux_for_PC),
        .is_write_reg       (is_write_reg),
        .is_write_mem       (is_write_mem),
        .is_write_from_mem  (is_write_from_mem),
        .is_R_type          (is_R_type),
        .is_I_type          (is_I_type),
        .is_J_type          (is_J_type),
        .opcode_alu         (opcode_alu),
        .is_nop             (is_nop),
        .halted             (halted),
        .retired            (retired),
        .stall_cycles       (stall_cycles)
    );

    assign outs = {is_load_PC, control_mux_for_PC, is_write_reg, is_write_mem, is_write_from_mem,
                   is_R_type, is_I_type, is_J_type, opcode_alu, is_nop, halted};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        exp_ret = 0;
    endtask

    // Starts in a FETCH cycle, ends in the FETCH cycle of the next instruction (or after max_c cycles)
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                       input int haz, input logic on_rt, input int max_c);
        opcode = op;
        funct = fn;
        is_alu_zero = zero;
        len = 0; n_nop = 0; n_wreg = 0; n_wmem = 0; n_load = 0;
        sel_q = '0; alu_q = '0; r_q = 0; i_q = 0; j_q = 0; fm_q = 0;
        for (int c = 1; c <= max_c; c++) begin
            is_full_rnum1 = !on_rt && c >= 2 && c <= haz + 1;
            is_full_rnum2 = on_rt && c >= 2 && c <= haz + 1;
            n_nop += int'(is_nop);
            n_wreg += int'(is_write_reg);
            n_wmem += int'(is_write_mem);
            n_load += int'(is_load_PC);
            if (is_load_PC) begin
                len = c;
                sel_q = control_mux_for_PC;
                alu_q = opcode_alu;
                r_q = is_R_type;
                i_q = is_I_type;
                j_q = is_J_type;
                fm_q = is_write_from_mem;
            end
            step();
            if (len != 0) break;
        end
        is_full_rnum1 = 1'b0;
        is_full_rnum2 = 1'b0;
    endtask

    initial begin
        step();
        step();
        check("reset_outs", 32'(outs), 0);
        check("reset_retired", 32'(retired), 0);
        check("reset_stall", 32'(stall_cycles), 0);
        rst = 1'b1;

        opcode = 6'h08;
        step();
        step();
        step();
        check("addi_wb_wreg", 32'(is_write_reg), 1);
        rst = 1'b0;
        #1;
        check("midwb_reset_wreg", 32'(is_write_reg), 0);
        check("midwb_reset_outs", 32'(outs), 0);
        step();
        rst = 1'b1;
        exp_ret = 0;

        run(6'h08, 6'h00, 0, 0, 0, 12);
        exp_ret++;
        check("post_reset_addi_len", 32'(len), 4);
        check("post_reset_retired", 32'(retired), 32'(exp_ret));

        run(6'h08, 6'h00, 0, 0, 0, 12);
        exp_ret++;
        check("addi_len", 32'(len), 4);
        check("addi_itype", 32'({r_q, i_q, j_q}), 3'b010);
        check("addi_alu", 32'(alu_q), 32'h20);
        check("addi_wreg", 32'(n_wreg), 1);
        run(6'h00, 6'h20, 0, 0, 0, 12);
        exp_ret++;
        check("radd_len", 32'(len), 4);
        check("radd_rtype", 32'({r_q, i_q, j_q}), 3'b100);
        check("radd_alu", 32'(alu_q), 32'h20);
        check("radd_retired", 32'(retired), 32'(exp_ret));

        run(6'h23, 6'h00, 0, 3, 0, 16);
        exp_ret++;
        check("lw_len", 32'(len), 8);
        check("lw_nops", 32'(n_nop), 3);
        check("lw_stall_cnt", 32'(stall_cycles), 3);
        check("lw_from_mem", 32'(fm_q), 1);
        check("lw_wreg", 32'(n_wreg), 1);

        run(6'h08, 6'h00, 0, 2, 1, 12);
        exp_ret++;
        check("addi_rt_haz_len", 32'(len), 4);
        run(6'h00, 6'h22, 0, 2, 1, 12);
        exp_ret++;
        check("rsub_rt_haz_len", 32'(len), 6);
        check("rsub_alu", 32'(alu_q), 32'h22);
        check("rt_stall_cnt", 32'(stall_cycles), 5);

        run(6'h04, 6'h00, 1, 0, 0, 12);
        exp_ret++;
        check("beq_z1_len", 32'(len), 4);
        check("beq_z1_sel", 32'(sel_q), 1);
        check("beq_z1_alu", 32'(alu_q), 32'h22);
        run(6'h04, 6'h00, 0, 0, 0, 12);
        exp_ret++;
        check("beq_z0_sel", 32'(sel_q), 0);
        check("beq_z0_alu", 32'(alu_q), 32'h22);
        check("beq_retired", 32'(retired), 32'(exp_ret));

        run(6'h02, 6'h00, 0, 0, 0, 12);
        exp_ret++;
        check("j_len", 32'(len), 3);
        check("j_jtype", 32'({r_q, i_q, j_q}), 3'b001);
        check("j_sel", 32'(sel_q), 2);

        run(6'h2B, 6'h00, 0, 0, 0, 12);
        exp_ret++;
        check("sw_len", 32'(len), 4);
        check("sw_wmem", 32'(n_wmem), 1);
        check("sw_wreg", 32'(n_wreg), 0);
        check("sw_sel", 32'(sel_q), 0);
        check("sw_retired", 32'(retired), 32'(exp_ret));

        run(6'h3F, 6'h00, 0, 0, 0, 22);
        check("halt_loads", 32'(n_load), 0);
        check("halt_halted", 32'(halted), 1);
        check("halt_strobes", 32'(outs), 1);
        check("halt_retired", 32'(retired), 32'(exp_ret));

        do_reset();
        check("rst_after_halt", 32'(halted), 0);
        check("rst_retired", 32'(retired), 0);
        run(6'h11, 6'h00, 0, 0, 0, 22);
        check("illegal_loads", 32'(n_load), 0);
        check("illegal_halted", 32'(halted), 1);
        check("illegal_strobes", 32'(outs), 1);

        do_reset();
        run(6'h02, 6'h00, 0, 0, 0, 12);
        check("recover_j_len", 32'(len), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
